// File: rtl/decoder_scanner_if.sv
// Decoder/scanner control and output bundle: enables, mode, select/load, dwell in; decode, index, wrap out.
interface decoder_scanner_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               g1;
  logic               g2a_bar;
  logic               g2b_bar;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output g1, g2a_bar, g2b_bar, mode, sel, load, dwell,
    input  out, idx, wrap
  );

  modport slave (
    input  g1, g2a_bar, g2b_bar, mode, sel, load, dwell,
    output out, idx, wrap
  );
endinterface

// File: rtl/decoder_scanner.sv
// Registered N-to-2^N one-hot decoder with 138-style enable gating and a dwell-timed auto-scan.
// Every output is a flop; the enable freezes index and dwell count without losing a step.
module decoder_scanner #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  decoder_scanner_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};

  logic               en;
  logic [SEL_W-1:0]   idx_q, idx_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic [OUT_W-1:0]   out_q, out_n;
  logic               wrap_q, wrap_n;
  logic [OUT_W-1:0]   onehot;

  assign en = bus.g1 & ~bus.g2a_bar & ~bus.g2b_bar;

  always_comb begin
    idx_n  = idx_q;
    cnt_n  = cnt_q;
    wrap_n = 1'b0;
    if (en) begin
      if (bus.load) begin
        idx_n = bus.sel;
        cnt_n = '0;
      end else if (!bus.mode) begin
        cnt_n = '0;
      end else if (cnt_q >= bus.dwell) begin
        // Live dwell compare: shrinking dwell below cnt forces a step now.
        cnt_n  = '0;
        idx_n  = idx_q + 1'b1;
        wrap_n = (idx_q == LAST_IDX);
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    onehot        = '0;
    onehot[idx_n] = 1'b1;
    out_n         = en ? (onehot ^ INACTIVE) : INACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= INACTIVE;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_n;
      cnt_q  <= cnt_n;
      out_q  <= out_n;
      wrap_q <= wrap_n;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scanner.sv
// Directed bench for decoder_scanner: active-high 3-bit instance and active-low 4-bit instance.
module tb_decoder_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_scanner_if #(.SEL_W(3), .DWELL_W(8)) bus_a ();
  decoder_scanner_if #(.SEL_W(4), .DWELL_W(8)) bus_b ();

  decoder_scanner #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  decoder_scanner #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] scan_exp [7];
    int n;
    scan_exp = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0};

    bus_a.g1 = 1'b1; bus_a.g2a_bar = 1'b0; bus_a.g2b_bar = 1'b0;
    bus_a.mode = 1'b0; bus_a.sel = '0; bus_a.load = 1'b0; bus_a.dwell = '0;
    bus_b.g1 = 1'b1; bus_b.g2a_bar = 1'b0; bus_b.g2b_bar = 1'b0;
    bus_b.mode = 1'b0; bus_b.sel = '0; bus_b.load = 1'b0; bus_b.dwell = '0;

    step();
    check("rst_out", 32'(bus_a.out), 32'h00);
    check("rst_idx", 32'(bus_a.idx), 32'd0);
    check("rst_wrap", 32'(bus_a.wrap), 32'd0);
    check("rst_out_b", 32'(bus_b.out), 32'hFFFF);
    rst = 1'b0;

    // Direct load of 5
    bus_a.sel = 3'd5; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    check("load5_out", 32'(bus_a.out), 32'h20);
    check("load5_idx", 32'(bus_a.idx), 32'd5);
    step(); step();
    check("load5_hold_out", 32'(bus_a.out), 32'h20);
    check("load5_hold_idx", 32'(bus_a.idx), 32'd5);

    // Enable gating at idx 3
    bus_a.sel = 3'd3; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    check("load3_out", 32'(bus_a.out), 32'h08);
    bus_a.g2a_bar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dis_out", 32'(bus_a.out), 32'h00);
      check("dis_idx", 32'(bus_a.idx), 32'd3);
    end
    bus_a.g2a_bar = 1'b0;
    step();
    check("reen_out", 32'(bus_a.out), 32'h08);

    // Scan from 6 with dwell 2, through the wrap
    bus_a.mode = 1'b1; bus_a.dwell = 8'd2; bus_a.sel = 3'd6; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("scan_idx", 32'(bus_a.idx), 32'(scan_exp[i]));
      check("scan_out", 32'(bus_a.out), 32'h1 << scan_exp[i]);
      check("scan_wrap", 32'(bus_a.wrap), (i == 6) ? 32'd1 : 32'd0);
      if (i < 6) step();
    end
    n = 0;
    do begin
      step();
      n++;
    end while (bus_a.wrap !== 1'b1 && n < 100);
    check("rotation_len", 32'(n), 32'd24);

    // Asynchronous reset mid-scan
    step(); step(); step(); step();
    check("pre_rst_idx", 32'(bus_a.idx), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(bus_a.out), 32'h00);
    check("async_rst_idx", 32'(bus_a.idx), 32'd0);
    check("async_rst_wrap", 32'(bus_a.wrap), 32'd0);
    step();
    rst = 1'b0;
    step(); step();
    check("restart_idx0", 32'(bus_a.idx), 32'd0);
    check("restart_out0", 32'(bus_a.out), 32'h01);
    step();
    check("restart_idx1", 32'(bus_a.idx), 32'd1);

    // Load wins over a due step, and the dwell count restarts
    bus_a.sel = 3'd4; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    step(); step();
    check("due_idx", 32'(bus_a.idx), 32'd4);
    bus_a.sel = 3'd2; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    check("loadwin_idx", 32'(bus_a.idx), 32'd2);
    check("loadwin_out", 32'(bus_a.out), 32'h04);
    step(); step();
    check("cnt_restart_idx", 32'(bus_a.idx), 32'd2);
    step();
    check("cnt_restart_step", 32'(bus_a.idx), 32'd3);

    // Loading 0 from 7 while a step is due must not wrap
    bus_a.sel = 3'd7; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    step(); step();
    bus_a.sel = 3'd0; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    check("load0_idx", 32'(bus_a.idx), 32'd0);
    check("load0_wrap", 32'(bus_a.wrap), 32'd0);

    // Dwell shrink from 9 to 1 at cnt 5
    bus_a.dwell = 8'd9; bus_a.sel = 3'd5; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("shrink_pre_idx", 32'(bus_a.idx), 32'd5);
    bus_a.dwell = 8'd1;
    step();
    check("shrink_step_idx", 32'(bus_a.idx), 32'd6);

    // Scan to direct holds; direct to scan waits dwell+1 cycles
    bus_a.mode = 1'b0;
    step(); step(); step();
    check("direct_hold_idx", 32'(bus_a.idx), 32'd6);
    bus_a.mode = 1'b1;
    step();
    check("rescan_wait_idx", 32'(bus_a.idx), 32'd6);
    step();
    check("rescan_step_idx", 32'(bus_a.idx), 32'd7);
    check("rescan_step_out", 32'(bus_a.out), 32'h80);

    // Active-low 4-bit instance
    bus_b.sel = 4'd9; bus_b.load = 1'b1;
    step();
    bus_b.load = 1'b0;
    check("al_load9_out", 32'(bus_b.out), 32'hFDFF);
    check("al_load9_idx", 32'(bus_b.idx), 32'd9);
    bus_b.g2b_bar = 1'b1;
    step();
    check("al_dis_out", 32'(bus_b.out), 32'hFFFF);
    check("al_dis_idx", 32'(bus_b.idx), 32'd9);
    bus_b.g2b_bar = 1'b0;
    step();
    check("al_reen_out", 32'(bus_b.out), 32'hFDFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
